// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - radix-2 FFT address and twiddle generator
//
// Walks an N = 2^N_LOG2 point in-place FFT stage by stage and, for every
// butterfly beat (s, j), presents the two operand addresses and the twiddle
// factor. All outputs come straight from flops.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              begin a run (honoured only when idle)
//   ready_i              downstream accepts the current beat
//   valid_o              current beat is valid
//   addr_a_o, addr_b_o   operand A / B memory addresses
//   twid_re_o, twid_im_o twiddle in Q(FRAC_BITS), sign-extended to DATA_WIDTH
//   stage_o              current stage index
//   last_o               final butterfly of the final stage
//   busy_o               run in progress (RUN or GAP)
//   done_o               one-cycle completion pulse
module fft_agu #(
  parameter int N_LOG2     = 4,
  parameter int DATA_WIDTH = 21,
  parameter int FRAC_BITS  = 15,
  parameter int STAGE_GAP  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [N_LOG2-1:0]     addr_a_o,
  output logic [N_LOG2-1:0]     addr_b_o,
  output logic [DATA_WIDTH-1:0] twid_re_o,
  output logic [DATA_WIDTH-1:0] twid_im_o,
  output logic [2:0]            stage_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int              JW       = N_LOG2 - 1;
  localparam logic [JW-1:0]   J_MAX    = '1;
  localparam logic [2:0]      S_MAX    = 3'(N_LOG2 - 1);
  localparam logic [3:0]      GAP_LOAD = 4'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  // The table is Q15; rescale to the requested fractional width.
  localparam int              SHL      = (FRAC_BITS >= 15) ? FRAC_BITS - 15 : 0;
  localparam int              SHR      = (FRAC_BITS < 15) ? 15 - FRAC_BITS : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              s_q, s_d;
  logic [JW-1:0]           j_q, j_d;
  logic [3:0]              gap_q, gap_d;

  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    last_q, last_d;
  logic [N_LOG2-1:0]       addr_a_q, addr_a_d;
  logic [N_LOG2-1:0]       addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0]   twid_re_q, twid_re_d;
  logic [DATA_WIDTH-1:0]   twid_im_q, twid_im_d;
  logic [2:0]              stage_q, stage_d;

  // W16^m, Q15; 17 bits so that +1.0 (32768) does not wrap.
  function automatic logic signed [16:0] tw_re(input logic [2:0] m);
    case (m)
      3'd0:    tw_re = 17'sd32768;
      3'd1:    tw_re = 17'sd30274;
      3'd2:    tw_re = 17'sd23170;
      3'd3:    tw_re = 17'sd12540;
      3'd4:    tw_re = 17'sd0;
      3'd5:    tw_re = -17'sd12540;
      3'd6:    tw_re = -17'sd23170;
      default: tw_re = -17'sd30274;
    endcase
  endfunction

  function automatic logic signed [16:0] tw_im(input logic [2:0] m);
    case (m)
      3'd0:    tw_im = 17'sd0;
      3'd1:    tw_im = -17'sd12540;
      3'd2:    tw_im = -17'sd23170;
      3'd3:    tw_im = -17'sd30274;
      3'd4:    tw_im = -17'sd32768;
      3'd5:    tw_im = -17'sd30274;
      3'd6:    tw_im = -17'sd23170;
      default: tw_im = -17'sd12540;
    endcase
  endfunction

  // Next-state and beat counters.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          s_d     = 3'd0;
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (valid_q && ready_i) begin
          if (j_q == J_MAX) begin
            j_d = '0;
            if (s_q == S_MAX) begin
              state_d = S_DONE;
            end else begin
              // Stage index advances now; it is not visible until RUN resumes.
              s_d = s_q + 3'd1;
              if (STAGE_GAP > 0) begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
              end
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_RUN;
        else               gap_d   = gap_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat decode from the next (s, j) so the registered outputs line up with
  // the state they describe; a stalled beat recomputes identical values.
  logic [N_LOG2-1:0]            j_ext, half, pos, addr_a;
  logic [2:0]                   m;
  logic signed [DATA_WIDTH-1:0] re_ext, im_ext;

  always_comb begin
    j_ext  = N_LOG2'(j_d);
    half   = N_LOG2'(1) << s_d;
    pos    = j_ext & (half - N_LOG2'(1));
    addr_a = ((j_ext >> s_d) << (s_d + 3'd1)) | pos;
    // m = k * 2^(4-N_LOG2) with k = pos << (N_LOG2-1-s), i.e. pos << (3-s).
    m      = 3'(4'(pos) << (3'd3 - s_d));
    re_ext = DATA_WIDTH'(tw_re(m));
    im_ext = DATA_WIDTH'(tw_im(m));

    valid_d   = (state_d == S_RUN);
    busy_d    = (state_d == S_RUN) || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
    last_d    = 1'b0;
    addr_a_d  = '0;
    addr_b_d  = '0;
    twid_re_d = '0;
    twid_im_d = '0;
    stage_d   = 3'd0;
    if (valid_d) begin
      last_d    = (s_d == S_MAX) && (j_d == J_MAX);
      addr_a_d  = addr_a;
      addr_b_d  = addr_a | half;   // bit s of addr_a is always clear
      twid_re_d = (re_ext <<< SHL) >>> SHR;
      twid_im_d = (im_ext <<< SHL) >>> SHR;
      stage_d   = s_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      s_q       <= 3'd0;
      j_q       <= '0;
      gap_q     <= 4'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      twid_re_q <= '0;
      twid_im_q <= '0;
      stage_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      j_q       <= j_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      last_q    <= last_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      twid_re_q <= twid_re_d;
      twid_im_q <= twid_im_d;
      stage_q   <= stage_d;
    end
  end

  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign last_o    = last_q;
  assign addr_a_o  = addr_a_q;
  assign addr_b_o  = addr_b_q;
  assign twid_re_o = twid_re_q;
  assign twid_im_o = twid_im_q;
  assign stage_o   = stage_q;

endmodule
